// File: rtl/spi_reg_controller.sv
// Byte-level sequencer behind SPISlave: decodes the command byte, answers reads
// from control registers or a frame-start status snapshot, and commits writes.
module spi_reg_controller #(
    parameter logic [7:0] ID_BYTE = 8'hD5
) (
    input  logic        clk_system,
    input  logic        reset_n,
    input  logic        slave_select_n,
    input  logic [7:0]  rd_data,
    input  logic        new_data,
    output logic        latch,
    output logic [7:0]  wr_data,
    input  logic [63:0] status_in,
    output logic [63:0] ctrl_regs,
    output logic [7:0]  ctrl_wr_strobe,
    output logic        frame_active,
    output logic        addr_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    logic        ss_meta_q, ss_sync_q;
    logic [1:0]  state_q, state_d;
    logic [6:0]  addr_q, addr_d;
    logic [63:0] ctrl_q, ctrl_d;
    logic [63:0] snap_q, snap_d;
    logic        latch_q, latch_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  strobe_q, strobe_d;
    logic        active_q, active_d;
    logic        err_q, err_d;
    logic [6:0]  addr_inc;

    assign addr_inc = addr_q + 7'd1;

    // 0x00-0x07 control, 0x08-0x0F snapshot, everything else reads as zero.
    function automatic logic [7:0] reg_value(input logic [6:0] a,
                                             input logic [63:0] ctrl,
                                             input logic [63:0] snap);
        logic [7:0] v;
        v = 8'h00;
        if (a[6:3] == 4'd0)
            v = ctrl[{a[2:0], 3'b000} +: 8];
        else if (a[6:3] == 4'd1)
            v = snap[{a[2:0], 3'b000} +: 8];
        return v;
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ctrl_d    = ctrl_q;
        snap_d    = snap_q;
        latch_d   = 1'b0;
        wr_data_d = wr_data_q;
        strobe_d  = 8'h00;
        active_d  = active_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!ss_sync_q) begin
                    snap_d    = status_in;
                    latch_d   = 1'b1;
                    wr_data_d = ID_BYTE;
                    active_d  = 1'b1;
                    state_d   = ST_CMD;
                end
            end
            ST_CMD: begin
                if (new_data) begin
                    addr_d  = rd_data[6:0];
                    err_d   = (rd_data[6:4] != 3'd0);
                    latch_d = 1'b1;
                    if (rd_data[7]) begin
                        wr_data_d = reg_value(rd_data[6:0], ctrl_q, snap_q);
                        state_d   = ST_READ;
                    end else begin
                        wr_data_d = rd_data;
                        state_d   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (new_data) begin
                    if (addr_q[6:3] == 4'd0) begin
                        ctrl_d[{addr_q[2:0], 3'b000} +: 8] = rd_data;
                        strobe_d[addr_q[2:0]]              = 1'b1;
                    end
                    err_d     = (addr_q[6:4] != 3'd0);
                    latch_d   = 1'b1;
                    wr_data_d = rd_data;
                    addr_d    = addr_inc;
                end
            end
            default: begin
                // The error is reported once the unmapped byte has been shifted out.
                if (new_data) begin
                    err_d     = (addr_q[6:4] != 3'd0);
                    addr_d    = addr_inc;
                    latch_d   = 1'b1;
                    wr_data_d = reg_value(addr_inc, ctrl_q, snap_q);
                end
            end
        endcase
        if (state_q != ST_IDLE && ss_sync_q) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk_system or negedge reset_n) begin
        if (!reset_n) begin
            ss_meta_q <= 1'b1;
            ss_sync_q <= 1'b1;
            state_q   <= ST_IDLE;
            addr_q    <= 7'd0;
            ctrl_q    <= 64'd0;
            snap_q    <= 64'd0;
            latch_q   <= 1'b0;
            wr_data_q <= 8'h00;
            strobe_q  <= 8'h00;
            active_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ss_meta_q <= slave_select_n;
            ss_sync_q <= ss_meta_q;
            state_q   <= state_d;
            addr_q    <= addr_d;
            ctrl_q    <= ctrl_d;
            snap_q    <= snap_d;
            latch_q   <= latch_d;
            wr_data_q <= wr_data_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
            err_q     <= err_d;
        end
    end

    assign latch          = latch_q;
    assign wr_data        = wr_data_q;
    assign ctrl_regs      = ctrl_q;
    assign ctrl_wr_strobe = strobe_q;
    assign frame_active   = active_q;
    assign addr_err       = err_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Bench for spi_reg_controller: byte-level SPISlave emulation, frame-level
// reference model and a per-cycle output comparison.
module tb_spi_reg_controller;

    logic        clk_system = 1'b0;
    logic        reset_n;
    logic        slave_select_n;
    logic [7:0]  rd_data;
    logic        new_data;
    logic [63:0] status_in;
    logic        latch;
    logic [7:0]  wr_data;
    logic [63:0] ctrl_regs;
    logic [7:0]  ctrl_wr_strobe;
    logic        frame_active;
    logic        addr_err;

    always #25 clk_system = ~clk_system;

    spi_reg_controller #(.ID_BYTE(8'hD5)) dut (
        .clk_system     (clk_system),
        .reset_n        (reset_n),
        .slave_select_n (slave_select_n),
        .rd_data        (rd_data),
        .new_data       (new_data),
        .latch          (latch),
        .wr_data        (wr_data),
        .status_in      (status_in),
        .ctrl_regs      (ctrl_regs),
        .ctrl_wr_strobe (ctrl_wr_strobe),
        .frame_active   (frame_active),
        .addr_err       (addr_err)
    );

    int tests = 0;
    int fails = 0;

    // Model register file and the per-frame view of the transaction.
    logic [7:0]  mctrl [8];
    logic [7:0]  msnap [8];
    int          k;
    logic [6:0]  a0;
    bit          is_rd;

    // Expected outputs for the current cycle (m_*) and for the next one (p_*).
    logic        m_latch, p_latch;
    logic [7:0]  m_wr, p_wr;
    logic [7:0]  m_strobe, p_strobe;
    logic        m_err, p_err;
    logic        m_active, p_active;
    logic [63:0] m_ctrl;

    bit          chk_en;
    bit          rnd_status;
    logic [7:0]  miso_q [$];
    logic [7:0]  strb_q [$];
    int          err_cnt;
    logic [7:0]  fb [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_ctrl();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = mctrl[i];
        return v;
    endfunction

    function automatic logic [7:0] mread(input int a);
        if (a < 8) return mctrl[a];
        if (a < 16) return msnap[a-8];
        return 8'h00;
    endfunction

    function automatic logic [7:0] qget(input int i);
        if (i < miso_q.size()) return miso_q[i];
        return 8'hxx;
    endfunction

    always @(negedge clk_system) begin
        if (chk_en) begin
            check("latch", {63'd0, latch}, {63'd0, m_latch});
            check("wr_data", {56'd0, wr_data}, {56'd0, m_wr});
            check("ctrl_wr_strobe", {56'd0, ctrl_wr_strobe}, {56'd0, m_strobe});
            check("addr_err", {63'd0, addr_err}, {63'd0, m_err});
            check("frame_active", {63'd0, frame_active}, {63'd0, m_active});
            check("ctrl_regs", ctrl_regs, m_ctrl);
            if (latch) miso_q.push_back(wr_data);
            if (ctrl_wr_strobe != 8'h00) strb_q.push_back(ctrl_wr_strobe);
            if (addr_err) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk_system);
        #1;
        m_latch  = p_latch;
        m_strobe = p_strobe;
        m_err    = p_err;
        if (p_latch) m_wr = p_wr;
        m_active = p_active;
        m_ctrl   = pack_ctrl();
        p_latch  = 1'b0;
        p_strobe = 8'h00;
        p_err    = 1'b0;
        new_data = 1'b0;
    endtask

    // Byte k of a frame: k=0 is the command, later bytes walk the address.
    task automatic send_byte(input logic [7:0] b);
        int a;
        rd_data  = b;
        new_data = 1'b1;
        if (k == 0) begin
            a0    = b[6:0];
            is_rd = b[7];
            p_err = (a0 >= 7'd16);
            p_wr  = is_rd ? mread(int'(a0)) : b;
        end else if (!is_rd) begin
            a = (int'(a0) + k - 1) % 128;
            if (a < 8) begin
                mctrl[a] = b;
                p_strobe = 8'(1 << a);
            end
            p_err = (a >= 16);
            p_wr  = b;
        end else begin
            a     = (int'(a0) + k) % 128;
            p_err = (((int'(a0) + k - 1) % 128) >= 16);
            p_wr  = mread(a);
        end
        p_latch = 1'b1;
        k++;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            if (rnd_status && $urandom_range(0, 3) == 0) status_in = {$urandom, $urandom};
            tick();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if ($urandom_range(0, 2) == 0) begin
                rd_data  = 8'($urandom);
                new_data = 1'b1;
            end
            tick();
        end
    endtask

    task automatic frame_start();
        slave_select_n = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) msnap[i] = status_in[8*i +: 8];
        p_latch  = 1'b1;
        p_wr     = 8'hD5;
        p_active = 1'b1;
        k        = 0;
        tick();
        gap(3);
    endtask

    // late in 0..2: the final byte arrives that many cycles after select rises.
    task automatic frame_end(input int late, input logic [7:0] b);
        slave_select_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == late) send_byte(b);
            if (c == 2) p_active = 1'b0;
            tick();
        end
    endtask

    task automatic run_frame(input int n, input int late);
        int last;
        frame_start();
        last = (late >= 0) ? n - 1 : n;
        for (int i = 0; i < last; i++) begin
            send_byte(fb[i]);
            tick();
            gap($urandom_range(1, 4));
        end
        frame_end(late, fb[n-1]);
        idle($urandom_range(2, 5));
    endtask

    task automatic clear_capture();
        miso_q.delete();
        strb_q.delete();
        err_cnt = 0;
    endtask

    initial begin
        #(50 * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        slave_select_n = 1'b1;
        new_data = 1'b0;
        rd_data = 8'h00;
        status_in = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 8; i++) begin
            mctrl[i] = 8'h00;
            msnap[i] = 8'h00;
        end
        {m_latch, p_latch, m_err, p_err, m_active, p_active} = '0;
        {m_wr, p_wr, m_strobe, p_strobe} = '0;
        m_ctrl = 64'd0;
        k = 0; a0 = 7'd0; is_rd = 1'b0;
        rnd_status = 1'b0;
        chk_en = 1'b1;
        err_cnt = 0;
        #5 reset_n = 1'b0;
        #100;
        tick();
        reset_n = 1'b1;
        idle(3);

        // Write burst
        clear_capture();
        fb[0] = 8'h02; fb[1] = 8'h11; fb[2] = 8'h22;
        run_frame(3, -1);
        check("wb_miso_cnt", 64'(miso_q.size()), 64'd4);
        check("wb_miso0", {56'd0, qget(0)}, 64'hD5);
        check("wb_miso1", {56'd0, qget(1)}, 64'h02);
        check("wb_miso2", {56'd0, qget(2)}, 64'h11);
        check("wb_regs", {48'd0, ctrl_regs[31:16]}, 64'h2211);
        check("wb_strb_cnt", 64'(strb_q.size()), 64'd2);
        if (strb_q.size() == 2) begin
            check("wb_strb0", {56'd0, strb_q[0]}, 64'h04);
            check("wb_strb1", {56'd0, strb_q[1]}, 64'h08);
        end

        // Read burst
        clear_capture();
        fb[0] = 8'h82; fb[1] = 8'h00; fb[2] = 8'h00;
        run_frame(3, -1);
        check("rb_miso0", {56'd0, qget(0)}, 64'hD5);
        check("rb_miso1", {56'd0, qget(1)}, 64'h11);
        check("rb_miso2", {56'd0, qget(2)}, 64'h22);

        // Status coherency
        clear_capture();
        status_in[7:0] = 8'h5A;
        frame_start();
        status_in[7:0] = 8'hFF;
        send_byte(8'h88);
        tick();
        gap(3);
        send_byte(8'h00);
        tick();
        gap(2);
        frame_end(-1, 8'h00);
        idle(3);
        check("st_miso1", {56'd0, qget(1)}, 64'h5A);

        // Unmapped read with wrap to reg0
        fb[0] = 8'h00; fb[1] = 8'h3C;
        run_frame(2, -1);
        clear_capture();
        fb[0] = 8'hFF; fb[1] = 8'h00; fb[2] = 8'h00;
        run_frame(3, -1);
        check("wr_miso0", {56'd0, qget(0)}, 64'hD5);
        check("wr_miso1", {56'd0, qget(1)}, 64'h00);
        check("wr_miso2", {56'd0, qget(2)}, 64'h3C);
        check("wr_err_cnt", 64'(err_cnt), 64'd2);

        // Abort before the data byte completes
        clear_capture();
        fb[0] = 8'h01;
        run_frame(1, -1);
        check("ab_strb_cnt", 64'(strb_q.size()), 64'd0);
        check("ab_reg1", {56'd0, ctrl_regs[15:8]}, 64'h00);

        // Data byte coinciding with the synchronized deassert
        fb[0] = 8'h05; fb[1] = 8'hAA;
        run_frame(2, 2);
        check("late_reg5", {56'd0, ctrl_regs[47:40]}, 64'hAA);

        // Reset in the middle of a frame
        frame_start();
        send_byte(8'h03);
        tick();
        #2;
        reset_n = 1'b0;
        slave_select_n = 1'b1;
        for (int i = 0; i < 8; i++) mctrl[i] = 8'h00;
        {m_latch, p_latch, m_err, p_err, m_active, p_active} = '0;
        {m_wr, p_wr, m_strobe, p_strobe} = '0;
        m_ctrl = 64'd0;
        #1;
        check("mr_ctrl", ctrl_regs, 64'd0);
        check("mr_active", {63'd0, frame_active}, 64'd0);
        check("mr_wr", {56'd0, wr_data}, 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        idle(3);

        // Randomized frames
        rnd_status = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int n;
            int late;
            logic [6:0] a;
            n = $urandom_range(1, 6);
            case ($urandom_range(0, 3))
                0: a = 7'($urandom_range(0, 7));
                1: a = 7'($urandom_range(8, 15));
                2: a = 7'($urandom_range(0, 127));
                default: a = 7'($urandom_range(124, 127));
            endcase
            fb[0] = {1'($urandom_range(0, 1)), a};
            for (int i = 1; i < n; i++) fb[i] = 8'($urandom);
            late = int'($urandom_range(0, 4)) - 2;
            run_frame(n, late);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_reg_controller.md
# spi_reg_controller

Register-access controller sitting directly behind `SPISlave` in the flight-controller FPGA. It sequences the slave byte-by-byte: it decodes the first received byte of each frame as a command, then loads response bytes through the slave's `latch`/`wr_data` port and commits write bytes into a bank of control registers. It also serves a coherent snapshot of read-only status registers to the SPI master (the flight processor).

## Interface
Parameters:
- `ID_BYTE`, 8'hD5: byte preloaded into the slave at frame start; the master sees it during the command byte.

Ports:
- `clk_system`  in  1  system clock (20 MHz); all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `slave_select_n`  in  1  raw SPI chip select, shared with `SPISlave`; asynchronous to `clk_system`
- `rd_data`  in  8  byte received by `SPISlave`
- `new_data`  in  1  one-cycle pulse from `SPISlave`: `rd_data` valid
- `latch`  out  1  one-cycle pulse: load `wr_data` into the slave shift register
- `wr_data`  out  8  next MISO byte
- `status_in`  in  64  status regs 8..15; byte i = bits [8i+7:8i]
- `ctrl_regs`  out  64  control regs 0..7, same packing
- `ctrl_wr_strobe`  out  8  one-hot, one-cycle pulse when control reg i is written
- `frame_active`  out  1  high while a frame is in progress
- `addr_err`  out  1  one-cycle pulse on access to address ≥ 0x10

## Operation
- `slave_select_n` passes through a 2-flop synchronizer; frame start/end are detected on the synchronized signal.
- Command byte: bit 7 = R/W (1 = read), bits [6:0] = start address A.
- Address map: 0x00–0x07 control regs (R/W); 0x08–0x0F status snapshot (RO); 0x10–0x7F unmapped.
- FSM states: IDLE, CMD, WRITE, READ.
  - IDLE: synchronized select falls -> snapshot `status_in`, pulse `latch` with `wr_data`=`ID_BYTE`, -> CMD.
  - CMD: on `new_data`, capture A and R/W. Read -> pulse `latch` with `wr_data`=reg[A], -> READ. Write -> pulse `latch` with `wr_data`=`rd_data` (echo), -> WRITE.
  - WRITE: on each `new_data`, write `rd_data` to reg[A] if A ≤ 7 and pulse `ctrl_wr_strobe[A]`; A 0x08–0x7F is ignored, plus `addr_err` if A ≥ 0x10. Echo `rd_data` via `latch`, then A <= A+1.
  - READ: on each `new_data` (dummy byte ignored), A <= A+1, then pulse `latch` with reg[A+1].
  - Any state: synchronized select rises -> IDLE. A partial byte is discarded, no register change.
- Unmapped reads return 0x00 and pulse `addr_err`. The command byte itself raises `addr_err` if A ≥ 0x10.
- Address increment is 7-bit and wraps 0x7F -> 0x00.
- Status reads return the snapshot taken at frame start, never live `status_in`.
- `new_data` in the same cycle the select deassert is seen: the byte is processed fully, then the FSM goes to IDLE.

## Timing
- Reset values: `latch`=0, `wr_data`=8'h00, `ctrl_regs`=0, `ctrl_wr_strobe`=0, `frame_active`=0, `addr_err`=0, FSM=IDLE, A=0.
- Frame start: select falls at cycle 0 -> `frame_active`=1 and the `ID_BYTE` latch pulse at cycle 3.
- `new_data` at cycle N -> `latch`, `wr_data`, `ctrl_regs`, `ctrl_wr_strobe` and `addr_err` are all registered and valid at cycle N+1.
- Frame end: select rises at cycle M -> `frame_active`=0 at cycle M+3.
- Requirement on the master: SCLK half-period ≥ 4 `clk_system` cycles, and ≥ 4 cycles between select fall and the first SCLK edge.
- Reset asserted mid-frame: all outputs return to their reset values immediately; the current frame is dropped.

## Test plan
- Reset: hold `reset_n`=0 for 100 ns -> all outputs at reset values; `ctrl_regs`=0.
- Write burst: frame 0x02, 0x11, 0x22 -> reg2=0x11 and reg3=0x22. `ctrl_wr_strobe` pulses 0x04 then 0x08. MISO returns D5, 02, 11.
- Read burst: reg2=0x11, reg3=0x22; frame 0x82, 0x00, 0x00 -> MISO returns D5, 11, 22.
- Status coherency: `status_in` byte 0 = 0x5A at select fall, changed to 0xFF mid-frame; read 0x88 -> returns 0x5A.
- Unmapped/wrap: read 0xFF then 2 dummy bytes -> MISO returns D5, 00, then reg0; `addr_err` pulses on the command byte and on the first data byte.
- Abort: write command 0x01, then select deasserted after 4 SCLK edges of the data byte -> reg1 unchanged, no strobe; `frame_active`=0 within 3 cycles.
